// File: rtl/banana_pkg.sv
// banana_pkg: shared state encoding, LFSR polynomial and screen geometry for the banana spawner
package banana_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_GAP, LAUNCH, LIVE} state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR that steps only when advance is high
module lfsr16
  import banana_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value
);
  always_ff @(posedge clk)
    if (reset) value <= SEED;
    else if (advance) value <= lfsr_next(value);
endmodule

// File: rtl/banana_spawner.sv
// banana_spawner: frame-paced launcher that picks a random start row and tracks the live banana
module banana_spawner
  import banana_pkg::*;
#(
  parameter int          MIN_GAP_FRAMES = 60,
  parameter int          GAP_RAND_BITS  = 6,
  parameter int          Y_MIN          = 32,
  parameter int          Y_MAX          = 440,
  parameter int          Y_RAND_BITS    = 8,
  parameter int          LIVE_TIMEOUT   = 300,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic        banana_hit,
  output logic        appear,
  output logic [10:0] initial_y,
  output logic        busy,
  output logic [7:0]  spawn_count
);
  localparam int GW = $clog2(MIN_GAP_FRAMES + 2**GAP_RAND_BITS + 1);
  localparam int LW = $clog2(LIVE_TIMEOUT + 1);
  localparam logic [15:0] GAP_MASK = 16'((32'd1 << GAP_RAND_BITS) - 32'd1);
  state_t state, state_n;
  logic [GW-1:0] gap, gap_load;
  logic [LW-1:0] live;
  logic [15:0] rnd;
  logic [11:0] y_sum;
  logic [10:0] y_new;
  logic hit_q, hit_now, sof, on_field, launch, retire;
  assign sof = startOfFrame && enable;
  assign on_field = state == LAUNCH || state == LIVE;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .advance(sof), .value(rnd));
  always_comb begin
    hit_now = hit_q || (banana_hit && on_field);
    gap_load = GW'(MIN_GAP_FRAMES) + GW'(rnd & GAP_MASK);
    y_sum = 12'(Y_MIN) + 12'(rnd >> (16 - Y_RAND_BITS));
    y_new = y_sum > 12'(Y_MAX) ? 11'(Y_MAX) : y_sum[10:0];
    launch = sof && state == WAIT_GAP && gap == '0;
    retire = sof && ((state == LAUNCH && hit_now) ||
                     (state == LIVE && (hit_now || live == LW'(LIVE_TIMEOUT - 1))));
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = !enable ? IDLE :
              !sof ? state :
              state == IDLE ? WAIT_GAP :
              state == WAIT_GAP ? (launch ? LAUNCH : WAIT_GAP) :
              retire ? WAIT_GAP : LIVE;
  always_comb begin
    appear = state == LAUNCH;
    busy = on_field;
  end
  always_ff @(posedge clk)
    if (reset) begin
      gap <= '0;
      live <= '0;
      hit_q <= 1'b0;
      initial_y <= 11'(Y_MIN);
      spawn_count <= '0;
    end else if (!enable) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_now && !sof;
      if (sof) begin
        if (state == IDLE || retire) gap <= gap_load;
        else if (state == WAIT_GAP && gap != '0) gap <= gap - 1'b1;
        live <= state == LIVE ? live + 1'b1 : '0;
        if (launch) begin
          initial_y <= y_new;
          spawn_count <= spawn_count + 8'd1;
        end
      end
    end
endmodule

// File: tb/tb_banana_spawner.sv
// tb_banana_spawner: randomized scoreboard bench against a frame-level model of the spawner
module tb_banana_spawner;
  localparam int MIN_GAP = 3;
  localparam int TO = 5;
  typedef struct { int y; int cnt; } exp_t;
  logic clk = 0, reset = 1, sof = 0, en = 0, en2 = 0, hit = 0;
  logic appear, busy, appear2, busy2;
  logic [10:0] initial_y, initial_y2;
  logic [7:0] spawn_count, spawn_count2;
  int checks = 0, failures = 0;
  bit chk_on = 0, prev_appear = 0;
  int m_wait, m_alive, m_y, m_cnt, drop = 0;
  bit m_run, m_show, m_hitp;
  logic [15:0] m_lfsr;
  exp_t q[$];
  always #5 clk = ~clk;
  banana_spawner #(.MIN_GAP_FRAMES(MIN_GAP), .GAP_RAND_BITS(2), .Y_MIN(400), .Y_MAX(440),
                   .Y_RAND_BITS(8), .LIVE_TIMEOUT(TO)) u1 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .enable(en), .banana_hit(hit),
    .appear(appear), .initial_y(initial_y), .busy(busy), .spawn_count(spawn_count));
  banana_spawner #(.MIN_GAP_FRAMES(3), .GAP_RAND_BITS(0), .Y_RAND_BITS(0)) u2 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .enable(en2), .banana_hit(1'b0),
    .appear(appear2), .initial_y(initial_y2), .busy(busy2), .spawn_count(spawn_count2));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step();
    logic [15:0] cur;
    int r, yy;
    if (reset) begin
      m_run = 0; m_wait = -1; m_show = 0; m_alive = -1; m_hitp = 0;
      m_lfsr = 16'hACE1; m_y = 400; m_cnt = 0; q.delete();
      return;
    end
    if (!en) begin
      m_run = 0; m_wait = -1; m_show = 0; m_alive = -1; m_hitp = 0;
      return;
    end
    if (hit && (m_show || m_alive >= 0)) m_hitp = 1;
    if (!sof) return;
    cur = m_lfsr;
    m_lfsr = cur[0] ? ((cur >> 1) ^ 16'hB400) : (cur >> 1);
    r = MIN_GAP + int'(cur % 16'd4);
    if (!m_run) begin
      m_run = 1; m_wait = r;
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (m_wait == 0) begin
      m_wait = -1; m_show = 1;
      yy = 400 + int'(cur / 16'd256);
      m_y = yy > 440 ? 440 : yy;
      m_cnt = (m_cnt + 1) % 256;
      q.push_back('{m_y, m_cnt});
    end else if (m_show) begin
      m_show = 0;
      if (m_hitp) begin m_hitp = 0; m_wait = r; end
      else m_alive = 0;
    end else if (m_alive >= 0) begin
      if (m_hitp || m_alive == TO - 1) begin m_alive = -1; m_hitp = 0; m_wait = r; end
      else m_alive++;
    end
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (chk_on) begin
      chk("appear", int'(appear), int'(m_show));
      chk("busy", int'(busy), int'(m_show || m_alive >= 0));
      if (appear && !prev_appear) begin
        if (q.size() == 0) chk("sb_unexpected_launch", 1, 0);
        else begin
          e = q.pop_front();
          chk("sb_initial_y", int'(initial_y), e.y);
          chk("sb_spawn_count", int'(spawn_count), e.cnt);
        end
      end
      prev_appear = appear;
    end
  end
  task automatic frame(input int len, input bit rnd);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      sof = (i == 0);
      if (rnd) begin
        hit = ($urandom_range(0, 19) == 0);
        if (drop > 0) begin
          en = 0;
          drop--;
        end else begin
          en = 1;
          if ($urandom_range(0, 199) == 0 || (m_show && i == 2 && $urandom_range(0, 3) == 0))
            drop = $urandom_range(1, 8);
        end
      end
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    chk_on = 1;
    for (int k = 0; k < 10; k++) frame(4, 0);
    chk("idle_appear", int'(appear), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_initial_y", int'(initial_y), 400);
    chk("idle_spawn_count", int'(spawn_count), 0);
    chk("idle2_initial_y", int'(initial_y2), 32);
    chk("idle2_spawn_count", int'(spawn_count2), 0);
    chk("idle2_appear", int'(appear2), 0);
    en2 = 1;
    for (int k = 1; k <= 6; k++) begin
      frame(4, 0);
      chk($sformatf("fixed_gap_appear_sof%0d", k), int'(appear2), int'(k == 5));
      chk($sformatf("fixed_gap_busy_sof%0d", k), int'(busy2), int'(k >= 5));
    end
    chk("fixed_gap_initial_y", int'(initial_y2), 32);
    chk("fixed_gap_spawn_count", int'(spawn_count2), 1);
    for (int k = 0; k < 500; k++) frame($urandom_range(3, 6), 1);
    hit = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("sb_empty", q.size(), 0);
    chk("final_spawn_count", int'(spawn_count), m_cnt);
    chk("final_initial_y", int'(initial_y), m_y);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
